// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide/modulo engine.
// Holds the alu_op encodings used by the control unit, the unit state
// encoding, the default datapath width and an op-decode helper.
// Optional feature macro used by muldiv_unit: MULDIV_EARLY_TERM_EN.
package muldiv_unit_pkg;

  localparam int WIDTH_DEFAULT = 16;

  localparam logic [4:0] OP_MUL = 5'd7;
  localparam logic [4:0] OP_DIV = 5'd2;
  localparam logic [4:0] OP_MOD = 5'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // True for the alu_op codes this unit executes.
  function automatic logic is_muldiv_op(input logic [4:0] op);
    case (op)
      OP_MUL, OP_DIV, OP_MOD: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One combinational restoring-division step.
// Ports:
//   rem_in  - current partial remainder (always < divisor, or divisor is 0)
//   dvd_bit - next dividend bit shifted in from the top
//   divisor - divisor
//   rem_out - partial remainder after this step
//   q_bit   - quotient bit produced by this step
// With divisor 0 every trial subtract succeeds, so repeated steps yield an
// all-ones quotient and a remainder equal to the dividend.
module muldiv_div_step
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] trial_s;
  logic [WIDTH:0] diff_s;

  // Trial subtract; restore (keep shifted value) when it would go negative.
  always_comb begin
    trial_s = {rem_in, dvd_bit};
    diff_s  = trial_s - {1'b0, divisor};
    rem_out = trial_s[WIDTH-1:0];
    q_bit   = 1'b0;
    if (trial_s >= {1'b0, divisor}) begin
      rem_out = diff_s[WIDTH-1:0];
      q_bit   = 1'b1;
    end else begin
      rem_out = trial_s[WIDTH-1:0];
      q_bit   = 1'b0;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply / divide / modulo engine driven by the
// control unit's start strobe and alu_op (MUL=7, DIV=2, MOD=5).
// Ports:
//   clk, rst            - clock (rising edge), async active-high reset
//   start, alu_op       - launch strobe and op select, sampled in IDLE only
//   op_a, op_b          - multiplicand/dividend, multiplier/divisor
//   result              - product low half, quotient or remainder (registered)
//   done_mul/div/mod    - one-cycle completion strobes
//   busy                - high in RUN and DONE
//   mul_ovf, div_zero   - product high half non-zero / divisor was zero
// Optional feature: define MULDIV_EARLY_TERM_EN to let MUL finish once the
// remaining multiplier bits are zero, and DIV/MOD by zero skip RUN.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       alu_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] result,
  output logic             done_mul,
  output logic             done_div,
  output logic             done_mod,
  output logic             busy,
  output logic             mul_ovf,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  state_t             state_r;
  logic [4:0]         op_r;
  logic [CNT_W-1:0]   count_r;
  // MUL: product accumulator; DIV/MOD: low half holds the partial remainder.
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] mcand_r;
  // MUL: remaining multiplier bits; DIV/MOD: dividend shifting out, quotient shifting in.
  logic [WIDTH-1:0]   lo_r;
  logic [WIDTH-1:0]   b_r;

  logic [WIDTH-1:0]   rem_next_s;
  logic               q_bit_s;
  logic               finish_s;
  logic [WIDTH-1:0]   result_next_s;
  logic               ovf_next_s;
  logic               dz_next_s;

  muldiv_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in  (acc_r[WIDTH-1:0]),
    .dvd_bit (lo_r[WIDTH-1]),
    .divisor (b_r),
    .rem_out (rem_next_s),
    .q_bit   (q_bit_s)
  );

  // RUN ends after WIDTH iterations (or early for MUL when enabled).
  always_comb begin
    finish_s = (count_r == CNT_LAST);
`ifdef MULDIV_EARLY_TERM_EN
    if ((op_r == OP_MUL) && (count_r != {CNT_W{1'b0}}) && (lo_r == {WIDTH{1'b0}})) begin
      finish_s = 1'b1;
    end else begin
      finish_s = (count_r == CNT_LAST);
    end
`endif
  end

  // Select the values captured into the output registers on entry to DONE.
  always_comb begin
    result_next_s = acc_r[WIDTH-1:0];
    ovf_next_s    = 1'b0;
    dz_next_s     = 1'b0;
    case (op_r)
      OP_MUL: begin
        result_next_s = acc_r[WIDTH-1:0];
        ovf_next_s    = |acc_r[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        result_next_s = lo_r;
        dz_next_s     = (b_r == {WIDTH{1'b0}});
      end
      OP_MOD: begin
        result_next_s = acc_r[WIDTH-1:0];
        dz_next_s     = (b_r == {WIDTH{1'b0}});
      end
      default: begin
        result_next_s = acc_r[WIDTH-1:0];
      end
    endcase
  end

  // Control FSM, datapath iteration and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      op_r     <= 5'd0;
      count_r  <= {CNT_W{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      mcand_r  <= {(2*WIDTH){1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      result   <= {WIDTH{1'b0}};
      done_mul <= 1'b0;
      done_div <= 1'b0;
      done_mod <= 1'b0;
      busy     <= 1'b0;
      mul_ovf  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done_mul <= 1'b0;
      done_div <= 1'b0;
      done_mod <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start && is_muldiv_op(alu_op)) begin
            op_r     <= alu_op;
            count_r  <= {CNT_W{1'b0}};
            mul_ovf  <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b1;
            acc_r    <= {(2*WIDTH){1'b0}};
            b_r      <= op_b;
            if (alu_op == OP_MUL) begin
              mcand_r <= {{WIDTH{1'b0}}, op_a};
              lo_r    <= op_b;
            end else begin
              mcand_r <= {(2*WIDTH){1'b0}};
              lo_r    <= op_a;
            end
`ifdef MULDIV_EARLY_TERM_EN
            if ((alu_op != OP_MUL) && (op_b == {WIDTH{1'b0}})) begin
              state_r  <= DONE;
              result   <= (alu_op == OP_DIV) ? {WIDTH{1'b1}} : op_a;
              div_zero <= 1'b1;
              done_div <= (alu_op == OP_DIV);
              done_mod <= (alu_op == OP_MOD);
            end else begin
              state_r <= RUN;
            end
`else
            state_r <= RUN;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (finish_s) begin
            state_r  <= DONE;
            result   <= result_next_s;
            mul_ovf  <= ovf_next_s;
            div_zero <= dz_next_s;
            done_mul <= (op_r == OP_MUL);
            done_div <= (op_r == OP_DIV);
            done_mod <= (op_r == OP_MOD);
          end else begin
            count_r <= count_r + 1'b1;
            if (op_r == OP_MUL) begin
              if (lo_r[0]) begin
                acc_r <= acc_r + mcand_r;
              end else begin
                acc_r <= acc_r;
              end
              mcand_r <= {mcand_r[2*WIDTH-2:0], 1'b0};
              lo_r    <= {1'b0, lo_r[WIDTH-1:1]};
            end else begin
              acc_r <= {{WIDTH{1'b0}}, rem_next_s};
              lo_r  <= {lo_r[WIDTH-2:0], q_bit_s};
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative 16-bit unsigned multiply/divide/modulo engine that sits directly downstream of the microcoded control unit. It executes the multi-cycle ALU operations: MUL (alu_op 7), DIV (alu_op 2) and MOD (alu_op 5). It takes the start strobe and alu_op from the control unit, computes over a fixed number of cycles, and returns per-operation done strobes plus a result for the ALU output mux.

Parameters:
WIDTH, 16, operand/result width; iteration count equals WIDTH.
OP_MUL, 5'd7, alu_op code for multiply.
OP_DIV, 5'd2, alu_op code for quotient.
OP_MOD, 5'd5, alu_op code for remainder.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  launch strobe from control unit; sampled only in IDLE.
alu_op  in  5  operation select; sampled together with start.
op_a  in  WIDTH  multiplicand / dividend (accumulator side).
op_b  in  WIDTH  multiplier / divisor (MDR side).
result  out  WIDTH  product low half, quotient, or remainder; registered.
done_mul  out  1  one-cycle completion strobe, MUL.
done_div  out  1  one-cycle completion strobe, DIV.
done_mod  out  1  one-cycle completion strobe, MOD.
busy  out  1  high in RUN and DONE.
mul_ovf  out  1  product high half non-zero; registered.
div_zero  out  1  DIV/MOD executed with op_b == 0; registered.

Behaviour:
- Reset, asynchronous: state=IDLE, count=0; result, mul_ovf, div_zero and all done strobes are 0; busy=0.
- States: IDLE, RUN, DONE.
- IDLE -> RUN: at a rising edge with start=1 and alu_op in {7,2,5}.
  - Latch op_a, op_b and alu_op.
  - Clear count, mul_ovf and div_zero.
  - start with any other alu_op is ignored; the unit stays in IDLE.
- RUN: one iteration per cycle; count increments; after WIDTH iterations go to DONE.
  - MUL: shift-add over a 2*WIDTH accumulator.
  - DIV/MOD: restoring divide, producing one quotient bit per cycle.
- DONE: lasts exactly one cycle.
  - Exactly one done_* is high, chosen by the latched op.
  - Then return to IDLE.
- Latency: start sampled at edge k; done_* is high in the cycle after edge k+WIDTH+1 (k+17 for WIDTH=16).
  - Fixed latency, independent of operand values.
- result, mul_ovf and div_zero update on entry to DONE. They then hold stable until the next accepted start, so the control unit may sample them while the done strobe is high.
- start asserted in RUN or DONE is ignored; there is no queueing and in-flight operands are not disturbed.
- Operand changes after the launch edge have no effect.
- MUL: result = (op_a*op_b)[WIDTH-1:0]; mul_ovf = |(op_a*op_b)[2*WIDTH-1:WIDTH].
- Divide by zero:
  - DIV returns result=all-ones (16'hFFFF); MOD returns result=op_a.
  - div_zero=1, normal latency, normal done strobe.
- Reset mid-operation aborts: IDLE, no done strobe, outputs cleared.
- A start in the same cycle as the DONE state is ignored; it may be re-issued one cycle later in IDLE.

Optional Feature:
MULDIV_EARLY_TERM_EN
- Defined:
  - MUL goes to DONE as soon as the remaining multiplier bits are all zero, with a minimum of 1 RUN cycle.
  - DIV/MOD with op_b==0 skips RUN: IDLE -> DONE, done at edge k+1.
  - Results are unchanged; only latency varies.
- Undefined: fixed WIDTH-cycle latency as above.

Decomposition:
- Shared package holds:
  - alu_op encodings (OP_MUL/OP_DIV/OP_MOD, matching the control unit's 7/2/5).
  - Unit state enum IDLE/RUN/DONE.
  - WIDTH default.
- One natural sub-module: muldiv_div_step, a combinational restoring step.
  - Inputs: partial remainder, dividend bit, divisor.
  - Outputs: next remainder, quotient bit.
- The MUL path and the FSM stay in the top module.

Test Plan:
- MUL 300*200 (0x012C*0x00C8), start at edge k -> done_mul only, at k+17; result=0xEA60; mul_ovf=0; busy high k+1..k+17.
- MUL 0x0100*0x0100 -> result=0x0000, mul_ovf=1.
- With MULDIV_EARLY_TERM_EN: MUL 5*3 -> result=0x000F, done well before k+17.
- DIV 1000/7 -> result=0x008E, done_div. MOD 1000/7 -> result=0x0006, done_mod. div_zero=0 for both.
- DIV 0x1234/0 -> result=0xFFFF, div_zero=1; MOD 0x1234/0 -> result=0x1234, div_zero=1. Both at normal latency; done at k+1 when MULDIV_EARLY_TERM_EN is defined.
- Start MUL, then pulse start with DIV operands at k+5 -> ignored; MUL result is unchanged.
- Start MUL, then assert rst at k+8 -> all outputs 0 immediately, no done strobe; a fresh start after reset completes normally.
- Start with alu_op=10 -> busy stays 0, no done strobe.
